dual_rail_sync_sink: RTL

- Clocked consumer at the output link of the asynchronous dual-rail pipelines, e.g. the Fibonacci generator's `out`/`ack_i` port.
- Samples the dual-rail codeword through a synchronizer and detects token completion.
- Decodes each token to binary, pushes it into a small FIFO and returns the acknowledge to the async stage.
- Presents a valid/ready stream to synchronous logic.

---
 rtl/dual_rail_sink_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/dual_rail_sync_sink.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dual_rail_sink_pkg.sv
// Shared types and constants for the dual-rail to synchronous sink.
package dual_rail_sink_pkg;

    typedef logic [1:0] dr_bit_t;

    typedef enum logic [0:0] {
        ENC_TP = 1'b0,
        ENC_FP = 1'b1
    } enc_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_e;

    localparam int MIN_SYNC_STAGES = 2;

    function automatic logic rail_one_hot(input dr_bit_t r);
        return r[1] ^ r[0];
    endfunction

    function automatic logic rail_both(input dr_bit_t r);
        return r[1] & r[0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head; an entry written on one edge
// becomes visible at the head one edge later.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [AW:0]      cnt_r;
    logic [AW:0]      remain_s;
    logic             empty_r;
    logic [WIDTH-1:0] pop_data_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full     = (cnt_r == DEPTH_C);
    assign empty    = empty_r;
    assign pop_data = pop_data_r;

    // Push is judged on the occupancy before this edge's pop.
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty_r;
        if (do_pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        remain_s = cnt_r - CW'(do_pop_s);
    end

    // Pointer, occupancy and registered head update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cnt_r      <= '0;
            empty_r    <= 1'b1;
            pop_data_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            cnt_r    <= remain_s + CW'(do_push_s);
            empty_r  <= (remain_s == '0);
            if (remain_s != '0) begin
                pop_data_r <= mem_r[rd_ptr_nxt_s];
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/dual_rail_sync_sink.sv
// Clocked sink for a dual-rail async link: synchronizes, detects completion,
// decodes into a FIFO and acknowledges. Define DUAL_RAIL_SYNC_SINK_COUNT_EN for tok_cnt.
module dual_rail_sync_sink
    import dual_rail_sink_pkg::*;
#(
    parameter     ENC         = "TP",
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  dr_bit_t [WIDTH-1:0] in,
    output logic                ack_o,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                err
`ifdef DUAL_RAIL_SYNC_SINK_COUNT_EN
    ,
    output logic [31:0]         tok_cnt
`endif
);

    localparam enc_e ENC_SEL = (ENC == "FP") ? ENC_FP : ENC_TP;
    localparam int   NSTG    = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
    localparam int   NRAIL   = 2 * WIDTH;

    logic [NRAIL-1:0] sync_r [NSTG];
    logic [NRAIL-1:0] s_s;
    logic [NRAIL-1:0] s_q_r;
    logic [NRAIL-1:0] prev_r;
    logic [NRAIL-1:0] cmp_s;
    logic [WIDTH-1:0] data_s;
    logic             stable_s;
    logic             tok_s;
    logic             ill_s;
    logic             quiet_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    state_e           state_r;
    logic             ack_r;
    logic             err_r;

    assign s_s       = sync_r[NSTG-1];
    assign stable_s  = (s_s == s_q_r);
    assign ack_o     = ack_r;
    assign err       = err_r;
    assign out_valid = ~empty_s;
    assign pop_s     = out_ready & ~empty_s;

    // Rail synchronizer chain plus one extra sample for the stability check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTG; i++) begin
                sync_r[i] <= '0;
            end
            s_q_r <= '0;
        end else begin
            sync_r[0] <= in;
            for (int i = 1; i < NSTG; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            s_q_r <= s_s;
        end
    end

    // Two-phase links are judged on transitions since the last capture,
    // four-phase links on absolute levels; both then share one completion test.
    always_comb begin
        if (ENC_SEL == ENC_FP) begin
            cmp_s = s_s;
        end else begin
            cmp_s = s_s ^ prev_r;
        end
        tok_s  = 1'b1;
        ill_s  = 1'b0;
        data_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tok_s     = tok_s & rail_one_hot(cmp_s[2*i +: 2]);
            ill_s     = ill_s | rail_both(cmp_s[2*i +: 2]);
            data_s[i] = cmp_s[2*i+1];
        end
        quiet_s = (cmp_s == '0);
        push_s  = (state_r == IDLE) && stable_s && tok_s && !full_s;
    end

    // Handshake FSM, acknowledge and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
            prev_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            if (stable_s && ill_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (push_s) begin
                        state_r <= ACKED;
                        if (ENC_SEL == ENC_FP) begin
                            ack_r <= 1'b1;
                        end else begin
                            ack_r  <= ~ack_r;
                            prev_r <= s_s;
                        end
                    end
                end
                ACKED: begin
                    if (stable_s && quiet_s) begin
                        state_r <= IDLE;
                        if (ENC_SEL == ENC_FP) begin
                            ack_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (data_s),
        .pop       (pop_s),
        .pop_data  (out_data),
        .full      (full_s),
        .empty     (empty_s)
    );

`ifdef DUAL_RAIL_SYNC_SINK_COUNT_EN
    logic [31:0] tok_cnt_r;

    assign tok_cnt = tok_cnt_r;

    // Free-running count of accepted tokens.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tok_cnt_r <= 32'd0;
        end else if (push_s) begin
            tok_cnt_r <= tok_cnt_r + 32'd1;
        end
    end
`endif

endmodule
